// File: rtl/acc_pipe32.sv
// acc_pipe32 -- accumulates NUM_OPS signed 32-bit operands into one result.
//
// Handshake: an operand is taken on a rising edge where valid_in && ready_o.
// A completed result is presented while out_valid_o=1. It is consumed on an
// edge where out_valid_o && out_ready_in. ready_o is low while a result is
// pending, so a consume and a new accept never happen on the same edge.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr_in          synchronous clear; overrides accept and consume
//   data_in         operand (two's complement)
//   valid_in        data_in valid
//   ready_o         operand can be accepted this cycle (combinational)
//   sum_o           accumulator register
//   c_o             sticky unsigned carry-out of any accumulate step
//   ovf_o           sticky signed overflow of any accumulate step
//   out_valid_o     sum_o/c_o/ovf_o hold a completed result
//   out_ready_in    downstream consumes the result
//   state_dbg       FSM state (00 IDLE, 01 ACC, 10 DONE)
//
// Build option: define ACC_PIPE32_SAT_EN to saturate sum_o on signed
// overflow instead of wrapping. Flags behave the same in both builds.

module acc_pipe32 #(
  parameter int NUM_OPS = 4  // operands per result, 2..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_in,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_o,
  output logic [31:0] sum_o,
  output logic        c_o,
  output logic        ovf_o,
  output logic        out_valid_o,
  input  logic        out_ready_in,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACC  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [7:0] LAST_COUNT = 8'(NUM_OPS - 1);

  logic [1:0]  state;
  logic [7:0]  count;
  logic        accept;
  logic [32:0] add_res;
  logic        add_carry;
  logic        add_ovf;
  logic [31:0] add_sum;

  assign ready_o     = ((state == IDLE) || (state == ACC)) && !clr_in;
  assign accept      = valid_in && ready_o;
  assign out_valid_o = (state == DONE);
  assign state_dbg   = state;

  // 33-bit add with zero carry-in; bit 32 is the unsigned carry-out.
  assign add_res   = {1'b0, sum_o} + {1'b0, data_in};
  assign add_carry = add_res[32];
  // Signed overflow: both operands share a sign and the result does not.
  assign add_ovf   = (sum_o[31] == data_in[31]) && (add_res[31] != sum_o[31]);

`ifdef ACC_PIPE32_SAT_EN
  // Clamp toward the operands' sign; later steps continue from the clamp.
  assign add_sum = add_ovf ? (data_in[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                           : add_res[31:0];
`else
  assign add_sum = add_res[31:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 8'd0;
      sum_o <= 32'd0;
      c_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else if (clr_in) begin
      state <= IDLE;
      count <= 8'd0;
      sum_o <= 32'd0;
      c_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sum_o <= data_in;
            count <= 8'd1;
            c_o   <= 1'b0;
            ovf_o <= 1'b0;
            state <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            sum_o <= add_sum;
            c_o   <= c_o | add_carry;
            ovf_o <= ovf_o | add_ovf;
            count <= count + 8'd1;
            if (count == LAST_COUNT) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_pipe32.sv
// Testbench for acc_pipe32 (NUM_OPS=4): directed steps followed by a random
// phase, with a reference model and an expected-result queue.

module tb_acc_pipe32;

  localparam int NUM_OPS = 4;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ACC  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_in;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_o;
  logic [31:0] sum_o;
  logic        c_o;
  logic        ovf_o;
  logic        out_valid_o;
  logic        out_ready_in;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  acc_pipe32 #(.NUM_OPS(NUM_OPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_in       (clr_in),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_o      (ready_o),
    .sum_o        (sum_o),
    .c_o          (c_o),
    .ovf_o        (ovf_o),
    .out_valid_o  (out_valid_o),
    .out_ready_in (out_ready_in),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  logic [33:0] exp_q[$];   // {ovf, c, sum}
  logic [33:0] cur_exp;
  int pass_cnt = 0;
  int total_cnt = 0;
  int results_seen = 0;

  logic [1:0]  m_state;
  logic [7:0]  m_count;
  logic [31:0] m_sum;
  logic        m_c;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_count = 8'd0;
    m_sum   = 32'd0;
    m_c     = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Reference behaviour for one rising edge given the inputs held across it.
  task automatic model_edge(input logic v, input logic [31:0] d,
                            input logic ordy, input logic clr);
    logic [32:0] r;
    logic        o;
    if (clr) begin
      model_reset();
    end else begin
      case (m_state)
        S_IDLE: if (v) begin
          m_sum = d; m_count = 8'd1; m_c = 1'b0; m_ovf = 1'b0; m_state = S_ACC;
        end
        S_ACC: if (v) begin
          r = {1'b0, m_sum} + {1'b0, d};
          o = (m_sum[31] == d[31]) && (r[31] != d[31]);
`ifdef ACC_PIPE32_SAT_EN
          m_sum = o ? (d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : r[31:0];
`else
          m_sum = r[31:0];
`endif
          m_c   = m_c | r[32];
          m_ovf = m_ovf | o;
          if (m_count == 8'(NUM_OPS - 1)) begin
            m_state = S_DONE;
            exp_q.push_back({m_ovf, m_c, m_sum});
          end
          m_count = m_count + 8'd1;
        end
        default: if (ordy) m_state = S_IDLE;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state"}, 64'(state_dbg), 64'(m_state));
    chk({tag, ".out_valid"}, 64'(out_valid_o), 64'(m_state == S_DONE));
    chk({tag, ".acc"}, 64'({ovf_o, c_o, sum_o}), 64'({m_ovf, m_c, m_sum}));
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives inputs, checks ready_o, crosses
  // the next edge and checks the registered outputs.
  task automatic step(input logic v, input logic [31:0] d,
                      input logic ordy, input logic clr);
    logic was_done;
    valid_in = v; data_in = d; out_ready_in = ordy; clr_in = clr;
    #1;
    chk("ready", 64'(ready_o), 64'((m_state != S_DONE) && !clr));
    was_done = (m_state == S_DONE);
    @(posedge clk);
    model_edge(v, d, ordy, clr);
    #1;
    check_outputs("step");
    if (m_state == S_DONE && !was_done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $error("FAIL scoreboard_empty observed=%h expected=queued_result",
               {ovf_o, c_o, sum_o});
      end else begin
        cur_exp = exp_q.pop_front();
        results_seen++;
      end
    end
    if (m_state == S_DONE)
      chk("result", 64'({ovf_o, c_o, sum_o}), 64'(cur_exp));
  endtask

  task automatic feed4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic consume();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("consume.idle", 64'(out_valid_o), 64'(0));
  endtask

  // Asynchronous reset applied between edges; outputs checked before any edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.async.sum", 64'(sum_o), 64'(0));
    chk("rst.async.flags", 64'({out_valid_o, ovf_o, c_o}), 64'(0));
    chk("rst.async.state", 64'(state_dbg), 64'(S_IDLE));
    valid_in = 1'b1; data_in = 32'd77; clr_in = 1'b0; out_ready_in = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst.held");
    valid_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst.release");
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'(1 + $urandom_range(0, 15));
      4: return 32'h4000_0000 + 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0; clr_in = 1'b0; data_in = 32'd0; valid_in = 1'b0;
    out_ready_in = 1'b0; cur_exp = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.ready", 64'(ready_o), 64'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1,2,3,4 back to back
    feed4(32'd1, 32'd2, 32'd3, 32'd4);
    chk("sum10.valid", 64'(out_valid_o), 64'(1));
    chk("sum10.value", 64'({ovf_o, c_o, sum_o}), 64'({1'b0, 1'b0, 32'd10}));
    consume();

    // Unsigned carry without signed overflow
    feed4(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("carry.value", 64'({ovf_o, c_o, sum_o}), 64'({1'b0, 1'b1, 32'd0}));
    consume();

    // Signed overflow
    feed4(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
`ifdef ACC_PIPE32_SAT_EN
    chk("ovf.value", 64'({ovf_o, c_o, sum_o}), 64'({1'b1, 1'b0, 32'h7FFF_FFFF}));
`else
    chk("ovf.value", 64'({ovf_o, c_o, sum_o}), 64'({1'b1, 1'b0, 32'h8000_0000}));
`endif

    // Hold the result with valid_in asserted: nothing may be accepted
    repeat (5) step(1'b1, 32'd99, 1'b0, 1'b0);
    consume();
    feed4(32'd7, 32'd8, 32'd9, 32'd10);
    chk("fresh.value", 64'(sum_o), 64'(34));
    consume();

    // Gap in ACC holds state
    step(1'b1, 32'd3, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'd500, 1'b0, 1'b0);
    chk("gap.count_hold", 64'(sum_o), 64'(3));

    // Clear after partial stream, overriding a simultaneous valid operand
    step(1'b1, 32'd4, 1'b0, 1'b0);
    step(1'b1, 32'd1000, 1'b0, 1'b1);
    chk("clr.zero", 64'({out_valid_o, ovf_o, c_o, sum_o}), 64'(0));
    feed4(32'd5, 32'd5, 32'd5, 32'd5);
    chk("clr.sum20", 64'(sum_o), 64'(20));
    // Clear in DONE wins over out_ready_in
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("clr.done", 64'({out_valid_o, sum_o}), 64'(0));

    // Reset mid-stream, then a full new stream
    step(1'b1, 32'd11, 1'b0, 1'b0);
    step(1'b1, 32'd12, 1'b0, 1'b0);
    async_reset();
    feed4(32'd5, 32'd5, 32'd5, 32'd5);
    chk("rst.sum20", 64'(sum_o), 64'(20));
    // Reset while a result is pending
    async_reset();
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Random phase: gaps, random back-pressure, rare clears
    for (int i = 0; i < 20000 && results_seen < 1000 + 8; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_operand(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    end
    chk("random.results", 64'(results_seen >= 1008), 64'(1));
    chk("scoreboard.drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/acc_pipe32.md
ACC_PIPE32 -- requirements
Module: acc_pipe32

Interface
REQ-001 Parameter NUM_OPS, default 4, operands summed per result; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clr_in  input  1  synchronous clear, active high.
REQ-005 data_in  input  32  operand, two's complement.
REQ-006 valid_in  input  1  data_in valid.
REQ-007 ready_o  output  1  block can accept data_in this cycle.
REQ-008 sum_o  output  32  accumulator register.
REQ-009 c_o  output  1  sticky unsigned carry-out of any accumulate step.
REQ-010 ovf_o  output  1  sticky signed overflow of any accumulate step.
REQ-011 out_valid_o  output  1  sum_o/c_o/ovf_o hold a completed result.
REQ-012 out_ready_in  input  1  downstream consumes result.

Function
REQ-013 FSM states IDLE, ACC, DONE; state, 8-bit count, sum_o, c_o, ovf_o all registered.
REQ-014 ready_o SHALL be combinational: 1 when state is IDLE or ACC and clr_in=0; else 0.
REQ-015 Accept occurs when valid_in=1 and ready_o=1; no other condition changes sum_o, count, or flags except clear/reset.
REQ-016 IDLE accept: sum_o<=data_in, count<=1, c_o<=0, ovf_o<=0, state->ACC.
REQ-017 ACC accept: 33-bit add sum_o+data_in (carry-in 0) completes in one cycle; sum_o<=result[31:0], c_o<=c_o|carry, ovf_o<=ovf_o|signed overflow, count<=count+1.
REQ-018 Signed overflow = operand sign bits equal and result bit 31 differs from them.
REQ-019 ACC accept with count=NUM_OPS-1 SHALL move to DONE; out_valid_o=1 from the next cycle (latency 1 after final accept).
REQ-020 DONE: outputs held stable, ready_o=0; out_ready_in=1 moves to IDLE, out_valid_o=0 next cycle.
REQ-021 Result consumed and new operand cannot share a cycle (ready_o=0 in DONE); first new accept earliest one cycle after handoff.
REQ-022 ACC with valid_in=0 SHALL hold all state indefinitely.
REQ-023 count SHALL never exceed NUM_OPS-1 in ACC; no wrap.
REQ-024 clr_in=1 in any state: next cycle state=IDLE, sum_o=0, count=0, c_o=0, ovf_o=0, out_valid_o=0; clr_in overrides simultaneous accept and out_ready_in.
REQ-025 out_valid_o=1 exactly when state=DONE.

Reset
REQ-026 rst_n=0 asynchronously forces state=IDLE, sum_o=0, count=0, c_o=0, ovf_o=0, out_valid_o=0; ready_o=1 once clr_in=0.
REQ-027 Reset mid-accumulation or in DONE discards partial/pending result; no output after release until NUM_OPS new accepts.
REQ-028 Reset release SHALL not cause an accept on that edge unless valid_in=1 is sampled with rst_n=1.

Configuration
REQ-029 Macro ACC_PIPE32_SAT_EN, when defined: on signed overflow sum_o<=0x7FFFFFFF (positive operands) or 0x80000000 (negative operands); ovf_o still set; later steps add from the saturated value.
REQ-030 Without ACC_PIPE32_SAT_EN: sum_o wraps modulo 2^32; ovf_o and c_o behave identically in both builds.

Verification
REQ-031 NUM_OPS=4, operands 1,2,3,4 back-to-back -> out_valid_o=1 one cycle after 4th accept, sum_o=10, c_o=0, ovf_o=0.
REQ-032 Operands 0xFFFFFFFF,1,0,0 -> sum_o=0, c_o=1, ovf_o=0.
REQ-033 Operands 0x7FFFFFFF,1,0,0 -> ovf_o=1; sum_o=0x80000000 without macro, 0x7FFFFFFF with ACC_PIPE32_SAT_EN.
REQ-034 Result held with out_ready_in=0 for 5 cycles while valid_in=1 -> ready_o=0, sum_o stable, no accept; out_ready_in=1 -> IDLE next cycle, next stream accumulates from fresh value.
REQ-035 clr_in after 2 accepts (and separately rst_n pulse mid-stream) -> all outputs 0 next cycle/immediately; following 4 operands 5,5,5,5 -> sum_o=20.
REQ-036 Random valid_in gaps, 1000 results vs reference model -> every sum_o/c_o/ovf_o matches, latency per REQ-019.
